imem_loader: RTL

Program loader that sits directly upstream of the pipelined core's instruction-memory write port. Receives a framed little-endian byte stream over a valid/ready handshake, assembles 32-bit instruction words, and writes them to consecutive word-aligned byte addresses through the core's `we0` / `wr_addr0` / `wr_din0` port. Verifies an XOR checksum, then raises `resetpc` to release the core's PC.

---
 rtl/imem_loader.sv | 136 +++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Program loader: receives a framed little-endian byte stream, writes 32-bit words
// into instruction memory, verifies an XOR checksum and then releases the core PC.
module imem_loader #(
    parameter int ADDR_W    = 9,
    parameter int MAX_WORDS = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              we0,
    output logic [ADDR_W-1:0] wr_addr0,
    output logic [31:0]       wr_din0,
    output logic              resetpc,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [7:0]        words_loaded,
    output logic [2:0]        state_dbg
);

    // Handshake: a byte moves on a rising edge where rx_valid && rx_ready are both 1.
    // rx_ready is a pure decode of the state register and never looks at rx_valid,
    // so a source holding rx_valid through WRITE keeps its byte until DATA resumes.

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR_LO = 3'd1,
        S_HDR_HI = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_CHK    = 3'd5,
        S_DONE   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    state_t      state;
    logic [7:0]  cnt_lo;
    logic [15:0] word_cnt;
    logic [1:0]  byte_idx;
    logic [23:0] asm_lo;
    logic [7:0]  chk_acc;
    logic [7:0]  word_idx;
    logic        xfer;
    logic [15:0] hdr_cnt;

    assign xfer    = rx_valid && rx_ready;
    assign hdr_cnt = {rx_data, cnt_lo};

    assign rx_ready     = (state == S_HDR_LO) || (state == S_HDR_HI) ||
                          (state == S_DATA)   || (state == S_CHK);
    assign busy         = rx_ready || (state == S_WRITE);
    assign we0          = (state == S_WRITE);
    assign done         = (state == S_DONE);
    assign err          = (state == S_ERR);
    assign resetpc      = (state == S_DONE);
    assign words_loaded = word_idx;
    assign state_dbg    = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt_lo   <= 8'd0;
            word_cnt <= 16'd0;
            byte_idx <= 2'd0;
            asm_lo   <= 24'd0;
            chk_acc  <= 8'd0;
            word_idx <= 8'd0;
            wr_addr0 <= '0;
            wr_din0  <= 32'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state    <= S_HDR_LO;
                        word_idx <= 8'd0;
                        chk_acc  <= 8'd0;
                        byte_idx <= 2'd0;
                    end
                end
                S_HDR_LO: begin
                    if (xfer) begin
                        cnt_lo <= rx_data;
                        state  <= S_HDR_HI;
                    end
                end
                S_HDR_HI: begin
                    if (xfer) begin
                        word_cnt <= hdr_cnt;
                        if (hdr_cnt == 16'd0 || hdr_cnt > 16'(MAX_WORDS))
                            state <= S_ERR;
                        else
                            state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        chk_acc  <= chk_acc ^ rx_data;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: asm_lo[7:0]   <= rx_data;
                            2'd1: asm_lo[15:8]  <= rx_data;
                            2'd2: asm_lo[23:16] <= rx_data;
                            default: begin
                                // Address and data are captured together so they only
                                // change when a complete word is about to be written.
                                wr_din0  <= {rx_data, asm_lo};
                                wr_addr0 <= ADDR_W'(word_idx) << 2;
                                state    <= S_WRITE;
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    word_idx <= word_idx + 8'd1;
                    if (16'(word_idx) + 16'd1 == word_cnt)
                        state <= S_CHK;
                    else
                        state <= S_DATA;
                end
                S_CHK: begin
                    if (xfer) begin
                        if (rx_data == chk_acc)
                            state <= S_DONE;
                        else
                            state <= S_ERR;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
